rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter N_STG, default 4, number of sequenced reset stages (legal range 1..16).
REQ-002 Parameter HOLD_CYC, default 16, consecutive locked cycles required before the first release (minimum 1).
REQ-003 Parameter GAP_CYC, default 8, cycles between an acknowledge and the next stage release (minimum 1).
REQ-004 Parameter ACK_TO, default 1024, acknowledge timeout in cycles (minimum 2).
REQ-005 SYSCLK  in  1  sole clock (the 200 MHz system clock).
REQ-006 RESETN  in  1  synchronous, active-low reset.
REQ-007 LOCKED_IN  in  1  PLL-locked status, already synchronous to SYSCLK.
REQ-008 SOFT_REQ  in  1  single-cycle request to restart the reset sequence.
REQ-009 STG_ACK  in  N_STG  level per stage: high means the stage has finished initialising.
REQ-010 STG_RST  out  N_STG  active-high reset per stage; bit 0 is released first.
REQ-011 SEQ_BUSY  out  1  high while the sequence is in progress.
REQ-012 SEQ_DONE  out  1  high when all stages are released and acknowledged.
REQ-013 SEQ_ERR  out  1  sticky acknowledge-timeout flag.
REQ-014 ERR_STG  out  max(1,clog2(N_STG))  index of the stage that timed out.

Function
REQ-015 The block SHALL use the states HOLD, WAIT_ACK, GAP, DONE and ERROR, with a stage index k and one shared cycle counter.
REQ-016 HOLD: all STG_RST=1 and SEQ_BUSY=1; the counter increments while LOCKED_IN=1 and clears when LOCKED_IN=0.
REQ-017 HOLD: on the edge where counter==HOLD_CYC-1 and LOCKED_IN=1, the block SHALL enter WAIT_ACK with k=0 and STG_RST[0]<=0 on that same edge.
REQ-018 WAIT_ACK: the counter increments each cycle; if STG_ACK[k]=1, the block SHALL go to GAP (k<N_STG-1) or DONE (k=N_STG-1) on the next edge.
REQ-019 WAIT_ACK: if the counter reaches ACK_TO-1 with STG_ACK[k]=0, the block SHALL enter ERROR, set SEQ_ERR=1, load ERR_STG=k and set all STG_RST=1.
REQ-020 GAP: after GAP_CYC cycles (counter 0..GAP_CYC-1), the block SHALL set k<=k+1, STG_RST[k+1]<=0 and enter WAIT_ACK on the same edge.
REQ-021 Only STG_ACK[k] SHALL be examined; acknowledges from other stages, including the loss of an acknowledge from an already-released stage, SHALL be ignored.
REQ-022 DONE: SEQ_BUSY=0 and SEQ_DONE=1, and all STG_RST bits SHALL be 0.
REQ-023 ERROR: SEQ_BUSY=0 and SEQ_DONE=0; the state is held until SOFT_REQ or reset.
REQ-024 In any state, SOFT_REQ=1 SHALL force HOLD on the next edge: all STG_RST=1, counter cleared, SEQ_DONE cleared, SEQ_ERR and ERR_STG cleared. SOFT_REQ takes priority over a simultaneous acknowledge or timeout.
REQ-025 In WAIT_ACK, GAP or DONE, LOCKED_IN=0 SHALL force HOLD as in REQ-024, except that SEQ_ERR and ERR_STG are unchanged; in ERROR, LOCKED_IN is ignored.
REQ-026 Latency with LOCKED_IN=1 from reset release and acknowledges always high: STG_RST[j] falls on edge HOLD_CYC+j*(GAP_CYC+1), where the first edge with RESETN=1 is edge 1; SEQ_DONE rises one edge after STG_RST[N_STG-1] falls.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 On RESETN=0 at a SYSCLK edge, the block SHALL set: state=HOLD, k=0, counter=0, STG_RST=all ones, SEQ_BUSY=1, SEQ_DONE=0, SEQ_ERR=0, ERR_STG=0.
REQ-029 A reset applied mid-sequence SHALL reassert every STG_RST bit on that same edge, and the sequence SHALL restart from HOLD.

Structure
REQ-030 Package rst_seq_pkg SHALL hold the state enum typedef and the default values of N_STG, HOLD_CYC, GAP_CYC and ACK_TO.
REQ-031 One sub-module, rst_seq_tmr, SHALL provide the shared clear/increment counter with a terminal-count compare; it is sized to the largest of HOLD_CYC, GAP_CYC and ACK_TO.

Verification
REQ-032 Defaults, LOCKED_IN=1 from edge 1, STG_ACK=4'hF -> STG_RST[0..3] fall on edges 16, 25, 34, 43; SEQ_DONE=1 at edge 44.
REQ-033 LOCKED_IN drops at edge 10 and returns at edge 12 -> STG_RST[0] falls at edge 27.
REQ-034 STG_ACK[2] held at 0 -> ERROR after 1024 WAIT_ACK cycles; SEQ_ERR=1, ERR_STG=2, STG_RST=4'hF.
REQ-035 SOFT_REQ pulse while in DONE -> STG_RST=4'hF and SEQ_BUSY=1 on the next edge; full sequence repeats with the same spacing.
REQ-036 SOFT_REQ on the same cycle as a timeout -> HOLD entered and SEQ_ERR stays 0.
REQ-037 RESETN pulsed low during GAP(1) -> all outputs at reset values on that edge; sequence restarts from HOLD.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the staged reset sequencer.
package rst_seq_pkg;

    localparam int DEF_N_STG    = 4;
    localparam int DEF_HOLD_CYC = 16;
    localparam int DEF_GAP_CYC  = 8;
    localparam int DEF_ACK_TO   = 1024;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_ACK,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width of a stage index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Status and control bundle between the reset sequencer and its environment.
interface rst_seq_ctrl_if
    import rst_seq_pkg::*;
#(
    parameter int N_STG = DEF_N_STG
) ();

    localparam int ERR_W = idx_w(N_STG);

    logic             LOCKED_IN;
    logic             SOFT_REQ;
    logic [N_STG-1:0] STG_ACK;
    logic [N_STG-1:0] STG_RST;
    logic             SEQ_BUSY;
    logic             SEQ_DONE;
    logic             SEQ_ERR;
    logic [ERR_W-1:0] ERR_STG;

    modport master (
        output LOCKED_IN, SOFT_REQ, STG_ACK,
        input  STG_RST, SEQ_BUSY, SEQ_DONE, SEQ_ERR, ERR_STG
    );

    modport slave (
        input  LOCKED_IN, SOFT_REQ, STG_ACK,
        output STG_RST, SEQ_BUSY, SEQ_DONE, SEQ_ERR, ERR_STG
    );

endinterface

// File: rtl/rst_seq_tmr.sv
// Shared cycle counter with clear/increment control and a terminal-count compare.
module rst_seq_tmr #(
    parameter int CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] tc_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compares the current count, so the terminal edge is the one where cnt_q == tc_val_i.
    assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Releases N_STG reset domains one at a time once the PLL is stably locked,
// waiting for each stage's acknowledge with a timeout.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_STG    = DEF_N_STG,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int GAP_CYC  = DEF_GAP_CYC,
    parameter int ACK_TO   = DEF_ACK_TO
) (
    input  logic SYSCLK,
    input  logic RESETN,
    rst_seq_ctrl_if.slave bus
);

    localparam int KW      = idx_w(N_STG);
    localparam int CNT_MAX = max3(HOLD_CYC, GAP_CYC, ACK_TO);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [KW-1:0]    K_LAST  = KW'(N_STG - 1);
    localparam logic [CNT_W-1:0] TC_HOLD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TC_GAP  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TC_ACK  = CNT_W'(ACK_TO - 1);

    seq_state_e       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [N_STG-1:0] stg_rst_q, stg_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [KW-1:0]    err_stg_q, err_stg_d;

    logic             go_hold;
    logic             tmr_clr;
    logic             tmr_inc;
    logic             tmr_tc;
    logic [CNT_W-1:0] tc_val;
    logic [KW-1:0]    k_inc;

    rst_seq_tmr #(
        .CNT_W (CNT_W)
    ) u_tmr (
        .clk_i    (SYSCLK),
        .rst_ni   (RESETN),
        .clr_i    (tmr_clr),
        .inc_i    (tmr_inc),
        .tc_val_i (tc_val),
        .tc_o     (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        stg_rst_d = stg_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        err_stg_d = err_stg_q;
        go_hold   = 1'b0;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        tc_val    = '0;
        k_inc     = k_q + 1'b1;

        // A soft restart outranks everything, including a same-cycle ack or timeout.
        if (bus.SOFT_REQ) begin
            go_hold   = 1'b1;
            err_d     = 1'b0;
            err_stg_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    tc_val = TC_HOLD;
                    if (!bus.LOCKED_IN) begin
                        tmr_clr = 1'b1;
                    end else if (tmr_tc) begin
                        state_d      = ST_WAIT_ACK;
                        k_d          = '0;
                        stg_rst_d    = '1;
                        stg_rst_d[0] = 1'b0;
                        tmr_clr      = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    tc_val = TC_ACK;
                    if (!bus.LOCKED_IN) begin
                        go_hold = 1'b1;
                    end else if (bus.STG_ACK[k_q]) begin
                        tmr_clr = 1'b1;
                        if (k_q == K_LAST) begin
                            state_d   = ST_DONE;
                            stg_rst_d = '0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else if (tmr_tc) begin
                        state_d   = ST_ERROR;
                        stg_rst_d = '1;
                        busy_d    = 1'b0;
                        done_d    = 1'b0;
                        err_d     = 1'b1;
                        err_stg_d = k_q;
                        tmr_clr   = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                ST_GAP: begin
                    tc_val = TC_GAP;
                    if (!bus.LOCKED_IN) begin
                        go_hold = 1'b1;
                    end else if (tmr_tc) begin
                        state_d          = ST_WAIT_ACK;
                        k_d              = k_inc;
                        stg_rst_d[k_inc] = 1'b0;
                        tmr_clr          = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                ST_DONE: begin
                    tmr_clr = 1'b1;
                    if (!bus.LOCKED_IN) begin
                        go_hold = 1'b1;
                    end
                end
                ST_ERROR: begin
                    tmr_clr = 1'b1;
                end
                default: begin
                    go_hold = 1'b1;
                end
            endcase
        end

        // Lock loss takes this path too but leaves the sticky error fields alone.
        if (go_hold) begin
            state_d   = ST_HOLD;
            k_d       = '0;
            stg_rst_d = '1;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            tmr_clr   = 1'b1;
            tmr_inc   = 1'b0;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!RESETN) begin
            state_q   <= ST_HOLD;
            k_q       <= '0;
            stg_rst_q <= '1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_stg_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            stg_rst_q <= stg_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_stg_q <= err_stg_d;
        end
    end

    assign bus.STG_RST  = stg_rst_q;
    assign bus.SEQ_BUSY = busy_q;
    assign bus.SEQ_DONE = done_q;
    assign bus.SEQ_ERR  = err_q;
    assign bus.ERR_STG  = err_stg_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios plus randomized runs against an
// event-time model of the release schedule.
module tb_rst_seq_ctrl;
    import rst_seq_pkg::*;

    localparam int N    = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 8;
    localparam int ATO  = 1024;
    localparam int BIG  = 1 << 30;

    // {STG_RST[3:0], SEQ_BUSY, SEQ_DONE, SEQ_ERR, ERR_STG[1:0]}
    localparam logic [8:0] RST_VALS = {4'hF, 1'b1, 1'b0, 1'b0, 2'b00};

    logic SYSCLK = 1'b0;
    logic RESETN;

    always #5 SYSCLK = ~SYSCLK;

    rst_seq_ctrl_if #(.N_STG(N)) bus ();

    rst_seq_ctrl #(
        .N_STG    (N),
        .HOLD_CYC (HOLD),
        .GAP_CYC  (GAP),
        .ACK_TO   (ATO)
    ) dut (
        .SYSCLK (SYSCLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int abs_edge = 0;

    // Event schedule relative to the last restart edge (edge 0).
    int r[N];
    int a[N];
    bit has_err;
    int err_j;
    int t;
    int fin;

    int fall[N];
    int fall_abs0;
    int done_e;
    int err_e;

    int dv[N];

    function automatic void build(input int d[N]);
        bit stopped;
        stopped = 1'b0;
        has_err = 1'b0;
        err_j   = 0;
        t       = BIG;
        r[0]    = HOLD;
        for (int j = 0; j < N; j++) begin
            if (stopped) begin
                r[j] = BIG;
                a[j] = BIG;
            end else if (d[j] <= ATO) begin
                a[j] = r[j] + d[j];
                if (j < N - 1) r[j+1] = a[j] + GAP;
            end else begin
                has_err = 1'b1;
                err_j   = j;
                t       = r[j] + ATO;
                a[j]    = BIG;
                stopped = 1'b1;
            end
        end
        fin = has_err ? t : a[N-1];
    endfunction

    function automatic logic [8:0] exp_at(input int e);
        logic [3:0] rs;
        logic       dn;
        if (has_err && e >= t) return {4'hF, 1'b0, 1'b0, 1'b1, 2'(err_j)};
        rs = 4'hF;
        for (int j = 0; j < N; j++) if (e >= r[j]) rs[j] = 1'b0;
        dn = !has_err && (e >= a[N-1]);
        return {rs, !dn, dn, 1'b0, 2'b00};
    endfunction

    function automatic logic [8:0] obs();
        return {bus.STG_RST, bus.SEQ_BUSY, bus.SEQ_DONE, bus.SEQ_ERR, bus.ERR_STG};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
        end
    endtask

    // kind: 1 = soft request, 2 = reset pulse, 3 = one-cycle lock loss, applied at edge 'at'.
    task automatic run_seq(input string tag, input int kind, input int at);
        logic [8:0]   o;
        logic [N-1:0] ack;
        for (int j = 0; j < N; j++) fall[j] = -1;
        done_e = -1;
        err_e  = -1;
        for (int e = 1; e <= at; e++) begin
            for (int j = 0; j < N; j++) begin
                if (r[j] < e && e <= a[j]) ack[j] = (e == a[j]);
                else ack[j] = 1'($urandom_range(0, 1));
            end
            bus.STG_ACK  = ack;
            bus.SOFT_REQ = (kind == 1 && e == at);
            RESETN       = !(kind == 2 && e == at);
            if (kind == 3 && e == at) bus.LOCKED_IN = 1'b0;
            else if (has_err && e > t) bus.LOCKED_IN = 1'($urandom_range(0, 1));
            else bus.LOCKED_IN = 1'b1;
            @(posedge SYSCLK);
            abs_edge++;
            @(negedge SYSCLK);
            o = obs();
            chk(tag, {23'd0, o}, {23'd0, (e == at) ? RST_VALS : exp_at(e)});
            if (e < at) begin
                for (int j = 0; j < N; j++) begin
                    if (fall[j] < 0 && !o[5+j]) begin
                        fall[j] = e;
                        if (j == 0) fall_abs0 = abs_edge;
                    end
                end
                if (done_e < 0 && o[3]) done_e = e;
                if (err_e < 0 && o[2]) err_e = e;
            end
        end
        bus.SOFT_REQ = 1'b0;
        RESETN       = 1'b1;
        bus.LOCKED_IN = 1'b1;
    endtask

    initial begin
        int kind;
        int at;
        bus.LOCKED_IN = 1'b1;
        bus.SOFT_REQ  = 1'b0;
        bus.STG_ACK   = '0;
        RESETN        = 1'b0;
        repeat (3) @(posedge SYSCLK);
        @(negedge SYSCLK);
        chk("reset_state", {23'd0, obs()}, {23'd0, RST_VALS});
        abs_edge = 0;

        // Lock low at edges 10 and 11 restarts the hold count.
        dv = '{1, 1, 1, 1};
        build(dv);
        run_seq("lockdrop_a", 3, 10);
        run_seq("lockdrop_b", 3, 1);
        run_seq("lockdrop_c", 2, fin + 2);
        chk("lockdrop_release_edge", fall_abs0, 27);

        run_seq("seq_default", 1, fin + 3);
        chk("fall0", fall[0], 16);
        chk("fall1", fall[1], 25);
        chk("fall2", fall[2], 34);
        chk("fall3", fall[3], 43);
        chk("done_edge", done_e, 44);

        run_seq("seq_repeat", 3, fin + 2);
        chk("repeat_fall0", fall[0], 16);
        chk("repeat_fall3", fall[3], 43);
        chk("repeat_done", done_e, 44);

        dv = '{1, 1, 2000, 1};
        build(dv);
        run_seq("ack_timeout", 1, t + 4);
        chk("timeout_edge", err_e, 34 + ATO);

        dv = '{1, 1, 1, ATO};
        build(dv);
        run_seq("ack_at_limit", 2, fin + 2);
        chk("limit_done_edge", done_e, 43 + ATO);
        chk("limit_no_err", err_e, -1);

        dv = '{1, 2000, 1, 1};
        build(dv);
        run_seq("soft_vs_timeout", 1, t);
        chk("soft_vs_timeout_no_err", err_e, -1);

        dv = '{1, 1, 1, 1};
        build(dv);
        run_seq("rst_in_gap1", 2, a[1] + 3);
        run_seq("after_rst", 1, fin + 1);
        chk("after_rst_fall0", fall[0], 16);
        chk("after_rst_done", done_e, 44);

        for (int it = 0; it < 8; it++) begin
            for (int j = 0; j < N; j++) dv[j] = int'($urandom_range(1, 12));
            if ($urandom_range(0, 3) == 0) dv[$urandom_range(0, N - 1)] = 1030;
            build(dv);
            kind = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) at = int'($urandom_range(1, fin));
            else at = fin + int'($urandom_range(1, 5));
            if (kind == 3 && has_err && at > t) kind = 1;
            run_seq("random_run", kind, at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
